// File: rtl/testadder_axil_regs_if.sv
// AXI4-Lite channel bundle between the PS/VIP master and the TestAdder register block.
// Widths default to the only supported configuration (5-bit byte address, 32-bit data).
interface testadder_axil_regs_if #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5
);
   logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR;
   logic [2:0]                      AWPROT;
   logic                            AWVALID;
   logic                            AWREADY;
   logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA;
   logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB;
   logic                            WVALID;
   logic                            WREADY;
   logic [1:0]                      BRESP;
   logic                            BVALID;
   logic                            BREADY;
   logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR;
   logic [2:0]                      ARPROT;
   logic                            ARVALID;
   logic                            ARREADY;
   logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA;
   logic [1:0]                      RRESP;
   logic                            RVALID;
   logic                            RREADY;

   modport master (
      output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
             ARADDR, ARPROT, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

   modport slave (
      input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
             ARADDR, ARPROT, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );
endinterface

// File: rtl/testadder_axil_regs.sv
// AXI4-Lite responder for TestAdder: REG0..REG3 RW, registered SUM = REG0+REG1, STATUS.
// Optional sum-ready interrupt and STATUS[2] pend flag enabled by defining TESTADDER_IRQ_EN.
module testadder_axil_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5
) (
   input  logic                  i_aclk,
   input  logic                  i_areset,
   testadder_axil_regs_if.slave  s_axil,
   output logic                  o_irq
);
   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int NB = C_S_AXI_DATA_WIDTH / 8;
   localparam int IW = C_S_AXI_ADDR_WIDTH - 2;

   typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
   typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

   wstate_t                 r_wstate, w_wstate_n;
   logic                    r_awready, w_awready_n;
   logic                    r_wready, w_wready_n;
   logic                    r_aw_done, w_aw_done_n;
   logic                    r_w_done, w_w_done_n;
   logic                    r_bvalid, w_bvalid_n;
   logic [1:0]              r_bresp, w_bresp_n;
   logic                    w_commit;
   logic [C_S_AXI_ADDR_WIDTH-1:0] r_awaddr;
   logic [DW-1:0]           r_wdata;
   logic [NB-1:0]           r_wstrb;
   logic [IW-1:0]           w_widx;

   rstate_t                 r_rstate, w_rstate_n;
   logic                    r_arready, w_arready_n;
   logic                    r_rvalid, w_rvalid_n;
   logic [DW-1:0]           r_rdata, w_rdata_n, w_rdata_mux;
   logic [1:0]              r_rresp, w_rresp_n, w_rresp_mux;
   logic [IW-1:0]           w_ridx;

   logic [DW-1:0]           r_reg [4];
   logic [DW-1:0]           r_sum;
   logic                    r_carry, r_ovf, r_sum_upd;
   logic [DW:0]             w_sum_full;
   logic [DW-1:0]           w_status;

   logic                    w_aw_hs, w_w_hs, w_ar_hs, w_r_hs;
   logic                    w_unused_bits;

   assign w_aw_hs  = s_axil.AWVALID && r_awready;
   assign w_w_hs   = s_axil.WVALID  && r_wready;
   assign w_ar_hs  = s_axil.ARVALID && r_arready;
   assign w_r_hs   = r_rvalid && s_axil.RREADY;
   assign w_widx   = r_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
   assign w_ridx   = s_axil.ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
   assign w_sum_full = {1'b0, r_reg[0]} + {1'b0, r_reg[1]};
   assign w_unused_bits = ^{s_axil.AWPROT, s_axil.ARPROT, r_awaddr[1:0], s_axil.ARADDR[1:0]};

   assign s_axil.AWREADY = r_awready;
   assign s_axil.WREADY  = r_wready;
   assign s_axil.BVALID  = r_bvalid;
   assign s_axil.BRESP   = r_bresp;
   assign s_axil.ARREADY = r_arready;
   assign s_axil.RVALID  = r_rvalid;
   assign s_axil.RDATA   = r_rdata;
   assign s_axil.RRESP   = r_rresp;

   // Write FSM: AW and W latch independently; commit one cycle after both are held.
   always_comb begin
      w_wstate_n  = r_wstate;
      w_awready_n = r_awready;
      w_wready_n  = r_wready;
      w_aw_done_n = r_aw_done;
      w_w_done_n  = r_w_done;
      w_bvalid_n  = r_bvalid;
      w_bresp_n   = r_bresp;
      w_commit    = 1'b0;
      case (r_wstate)
         W_IDLE: begin
            if (r_aw_done && r_w_done) begin
               w_commit    = 1'b1;
               w_aw_done_n = 1'b0;
               w_w_done_n  = 1'b0;
               w_awready_n = 1'b0;
               w_wready_n  = 1'b0;
               w_bvalid_n  = 1'b1;
               w_bresp_n   = (w_widx <= IW'(5)) ? 2'b00 : 2'b10;
               w_wstate_n  = W_RESP;
            end else begin
               if (w_aw_hs) begin
                  w_aw_done_n = 1'b1;
                  w_awready_n = 1'b0;
               end else begin
                  w_awready_n = !r_aw_done;
               end
               if (w_w_hs) begin
                  w_w_done_n = 1'b1;
                  w_wready_n = 1'b0;
               end else begin
                  w_wready_n = !r_w_done;
               end
            end
         end
         W_RESP: begin
            if (s_axil.BREADY) begin
               w_bvalid_n  = 1'b0;
               w_bresp_n   = 2'b00;
               w_awready_n = 1'b1;
               w_wready_n  = 1'b1;
               w_wstate_n  = W_IDLE;
            end else begin
               w_wstate_n  = W_RESP;
            end
         end
         default: w_wstate_n = W_IDLE;
      endcase
   end

   // Write FSM state and handshake outputs.
   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) begin
         r_wstate  <= W_IDLE;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= 2'b00;
      end else begin
         r_wstate  <= w_wstate_n;
         r_awready <= w_awready_n;
         r_wready  <= w_wready_n;
         r_aw_done <= w_aw_done_n;
         r_w_done  <= w_w_done_n;
         r_bvalid  <= w_bvalid_n;
         r_bresp   <= w_bresp_n;
      end
   end

   // Captured write address and data.
   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) begin
         r_awaddr <= '0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
      end else begin
         if (w_aw_hs) r_awaddr <= s_axil.AWADDR;
         if (w_w_hs) begin
            r_wdata <= s_axil.WDATA;
            r_wstrb <= s_axil.WSTRB;
         end
      end
   end

   // Operand/scratch registers; SUM and STATUS writes fall outside this range and drop.
   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) begin
         for (int i = 0; i < 4; i++) r_reg[i] <= '0;
      end else if (w_commit && (w_widx < IW'(4))) begin
         for (int b = 0; b < NB; b++) begin
            if (r_wstrb[b]) r_reg[w_widx[1:0]][8*b +: 8] <= r_wdata[8*b +: 8];
         end
      end
   end

   // SUM follows the commit by one cycle so it sees the freshly written operands.
   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) begin
         r_sum_upd <= 1'b0;
         r_sum     <= '0;
         r_carry   <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         r_sum_upd <= w_commit && (w_widx < IW'(2));
         if (r_sum_upd) begin
            r_sum   <= w_sum_full[DW-1:0];
            r_carry <= w_sum_full[DW];
            r_ovf   <= (r_reg[0][DW-1] == r_reg[1][DW-1]) && (w_sum_full[DW-1] != r_reg[0][DW-1]);
         end
      end
   end

`ifdef TESTADDER_IRQ_EN
   logic r_irq_pend;
   logic r_rd_status;

   // Pend flag: set on SUM update, cleared by the R handshake of a STATUS read; set wins.
   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) begin
         r_irq_pend  <= 1'b0;
         r_rd_status <= 1'b0;
      end else begin
         if (w_ar_hs) r_rd_status <= (w_ridx == IW'(5));
         if (r_sum_upd) begin
            r_irq_pend <= 1'b1;
         end else if (w_r_hs && r_rd_status) begin
            r_irq_pend <= 1'b0;
         end
      end
   end

   assign w_status = {{(DW-3){1'b0}}, r_irq_pend, r_ovf, r_carry};
   assign o_irq    = r_irq_pend;
`else
   assign w_status = {{(DW-2){1'b0}}, r_ovf, r_carry};
   assign o_irq    = 1'b0;
`endif

   // Read decode on the live register values, so a same-cycle commit is not yet visible.
   always_comb begin
      w_rdata_mux = '0;
      w_rresp_mux = 2'b00;
      case (w_ridx)
         IW'(0):  w_rdata_mux = r_reg[0];
         IW'(1):  w_rdata_mux = r_reg[1];
         IW'(2):  w_rdata_mux = r_reg[2];
         IW'(3):  w_rdata_mux = r_reg[3];
         IW'(4):  w_rdata_mux = r_sum;
         IW'(5):  w_rdata_mux = w_status;
         default: w_rresp_mux = 2'b10;
      endcase
   end

   // Read FSM: one outstanding read; data held until the R handshake.
   always_comb begin
      w_rstate_n  = r_rstate;
      w_arready_n = r_arready;
      w_rvalid_n  = r_rvalid;
      w_rdata_n   = r_rdata;
      w_rresp_n   = r_rresp;
      case (r_rstate)
         R_IDLE: begin
            if (w_ar_hs) begin
               w_arready_n = 1'b0;
               w_rvalid_n  = 1'b1;
               w_rdata_n   = w_rdata_mux;
               w_rresp_n   = w_rresp_mux;
               w_rstate_n  = R_DATA;
            end else begin
               w_arready_n = 1'b1;
            end
         end
         R_DATA: begin
            if (s_axil.RREADY) begin
               w_rvalid_n  = 1'b0;
               w_arready_n = 1'b1;
               w_rstate_n  = R_IDLE;
            end else begin
               w_rstate_n  = R_DATA;
            end
         end
         default: w_rstate_n = R_IDLE;
      endcase
   end

   // Read FSM state and registered read channel outputs.
   always_ff @(posedge i_aclk or posedge i_areset) begin
      if (i_areset) begin
         r_rstate  <= R_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= 2'b00;
      end else begin
         r_rstate  <= w_rstate_n;
         r_arready <= w_arready_n;
         r_rvalid  <= w_rvalid_n;
         r_rdata   <= w_rdata_n;
         r_rresp   <= w_rresp_n;
      end
   end
endmodule
